spi_regbank_arbiter: RTL and testbench
======================================

Name: spi_regbank_arbiter

Overview:
- Shares one single-port synchronous register RAM (512 x 32) between the SPI slave's register-access strobes and a local host port with a valid/ready handshake.
- The SPI side cannot be back-pressured, so it always wins arbitration.
- The host is stalled through `ready` whenever it loses.
- Sits between the SPI slave, the register RAM and the on-chip control fabric; it returns registered read data to the SPI slave for serialisation on miso.

Parameters:
- AW, 9, word-address width.
- DW, 32, data width.
- HOST_MAX_WAIT, 64, host stall cycles that set the starvation flag.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- spi_wr_en  in  1  single-cycle SPI write strobe
- spi_wr_addr  in  AW  SPI write address
- spi_wr_data  in  DW  SPI write data
- spi_rd_en  in  1  single-cycle SPI read strobe
- spi_rd_addr  in  AW  SPI read address
- spi_rd_data  out  DW  last SPI read result, held
- spi_rd_valid  out  1  one-cycle pulse when spi_rd_data updates
- host_req_valid  in  1  host request valid
- host_req_we  in  1  1 = write, 0 = read
- host_req_addr  in  AW  host address
- host_req_wdata  in  DW  host write data
- host_req_ready  out  1  host request accepted this cycle
- host_rsp_valid  out  1  one-cycle response pulse
- host_rsp_rdata  out  DW  read data; 0 for writes
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid the cycle after mem_en with mem_we = 0
- spi_rd_ovf  out  1  sticky: an SPI read was overwritten while pending
- host_starve  out  1  sticky: host waited HOST_MAX_WAIT cycles

Behaviour:
- Reset: all outputs are 0, except host_req_ready, which follows its combinational equation. rd_pend, issue tag, wait counter and sticky flags are cleared. A reset asserted mid-operation discards the pending read and any in-flight response; no valid pulse follows.
- Grant priority each cycle, exactly one grant:
  1. spi_wr_en
  2. rd_pend (the one-deep SPI read holding register)
  3. spi_rd_en
  4. host_req_valid
- host_req_ready = host_req_valid & !spi_wr_en & !rd_pend & !spi_rd_en. The host transfer completes on valid & ready. The host must hold its request stable until then.
- Pending register:
  - spi_rd_en that is not granted (it loses to spi_wr_en) loads rd_pend and its address.
  - If rd_pend is already set and is not granted that cycle, the new address overwrites it and spi_rd_ovf is set.
- RAM drive: mem_en = any grant; mem_we, mem_addr and mem_wdata come from the winner.
- Issue tag register, values NONE / SPI / HOST, tracks reads one cycle:
  - Tag SPI: spi_rd_data <= mem_rdata and spi_rd_valid = 1. Total latency is 2 cycles from spi_rd_en when uncontended, 3 when deferred.
  - Tag HOST: host_rsp_valid = 1 and host_rsp_rdata = mem_rdata.
  - A granted host write pulses host_rsp_valid one cycle later with rdata 0.
- spi_rd_data holds its value between SPI reads.
- RAM is read-first. A read followed by a write to the same address in the next cycle returns old data.
- Wait counter:
  - Increments while host_req_valid & !host_req_ready, saturating at HOST_MAX_WAIT.
  - Clears on a host transfer.
  - Reaching HOST_MAX_WAIT sets host_starve. The flag does not change priority.
- Sticky flags clear only on rst.
- Back-to-back SPI strobes on consecutive cycles are legal. Simultaneous spi_wr_en and spi_rd_en: write first, read next cycle.

Decomposition:
- Package spi_regbank_pkg holds AW_DEF, DW_DEF, and the issue-tag enum (TAG_NONE, TAG_SPI, TAG_HOST).
- One natural sub-module, spi_reg_grant: the combinational fixed-priority grant and mux.
- The pending register, issue tag, counters and response registers stay in the top.

Test Plan:
- Reset then idle: all outputs 0; host_req_ready = 0 with host_req_valid = 0.
- Host writes 32'hAAAA_0787 to 0x010, then spi_rd_en at 0x010 → spi_rd_valid 2 cycles later with spi_rd_data = 32'hAAAA_0787, held afterwards.
- spi_wr_en (0x005, 32'h1234_5678) and spi_rd_en (0x005) in the same cycle → write granted first, then the read. spi_rd_valid 3 cycles after the strobe with 32'h1234_5678.
- Host read of 0x020 pending while SPI strobes arrive on 3 consecutive cycles → host_req_ready stays 0 through those cycles. The host is granted the first free cycle and gets its response the next cycle.
- spi_wr_en + spi_rd_en (0x001), then spi_wr_en + spi_rd_en (0x002) on the next cycle → spi_rd_ovf = 1 and only the 0x002 read returns.
- Host held off for 64 cycles by SPI strobes injected at every cycle → host_starve = 1. rst mid-read → no spi_rd_valid or host_rsp_valid pulse, flags cleared.

Source files
------------

// File: rtl/spi_regbank_pkg.sv
// Shared widths and enumerations for the SPI / host register-bank arbiter.
package spi_regbank_pkg;
    localparam int unsigned AW_DEF = 9;
    localparam int unsigned DW_DEF = 32;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_SPI,
        TAG_HOST
    } issue_tag_t;

    typedef enum logic [2:0] {
        GNT_NONE,
        GNT_SPI_WR,
        GNT_PEND,
        GNT_SPI_RD,
        GNT_HOST
    } grant_t;
endpackage

// File: rtl/spi_regbank_arbiter_grant.sv
// Fixed-priority grant (SPI write > pending read > SPI read > host) and RAM mux.
module spi_reg_grant
    import spi_regbank_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic          spi_wr_en,
    input  logic [AW-1:0] spi_wr_addr,
    input  logic [DW-1:0] spi_wr_data,
    input  logic          rd_pend,
    input  logic [AW-1:0] pend_addr,
    input  logic          spi_rd_en,
    input  logic [AW-1:0] spi_rd_addr,
    input  logic          host_req_valid,
    input  logic          host_req_we,
    input  logic [AW-1:0] host_req_addr,
    input  logic [DW-1:0] host_req_wdata,
    output grant_t        grant,
    output logic          host_req_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata
);

    always_comb begin
        grant     = GNT_NONE;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (spi_wr_en) begin
            grant     = GNT_SPI_WR;
            mem_we    = 1'b1;
            mem_addr  = spi_wr_addr;
            mem_wdata = spi_wr_data;
        end else if (rd_pend) begin
            grant    = GNT_PEND;
            mem_addr = pend_addr;
        end else if (spi_rd_en) begin
            grant    = GNT_SPI_RD;
            mem_addr = spi_rd_addr;
        end else if (host_req_valid) begin
            grant     = GNT_HOST;
            mem_we    = host_req_we;
            mem_addr  = host_req_addr;
            mem_wdata = host_req_we ? host_req_wdata : '0;
        end
    end

    assign mem_en         = (grant != GNT_NONE);
    assign host_req_ready = host_req_valid & ~spi_wr_en & ~rd_pend & ~spi_rd_en;

endmodule

// File: rtl/spi_regbank_arbiter.sv
// Shares a single-port register RAM between SPI register strobes (never stalled)
// and a valid/ready host port; returns registered SPI read data and host responses.
module spi_regbank_arbiter
    import spi_regbank_pkg::*;
#(
    parameter int unsigned AW            = AW_DEF,
    parameter int unsigned DW            = DW_DEF,
    parameter int unsigned HOST_MAX_WAIT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          spi_wr_en,
    input  logic [AW-1:0] spi_wr_addr,
    input  logic [DW-1:0] spi_wr_data,
    input  logic          spi_rd_en,
    input  logic [AW-1:0] spi_rd_addr,
    output logic [DW-1:0] spi_rd_data,
    output logic          spi_rd_valid,
    input  logic          host_req_valid,
    input  logic          host_req_we,
    input  logic [AW-1:0] host_req_addr,
    input  logic [DW-1:0] host_req_wdata,
    output logic          host_req_ready,
    output logic          host_rsp_valid,
    output logic [DW-1:0] host_rsp_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          spi_rd_ovf,
    output logic          host_starve
);

    localparam int unsigned WW = $clog2(HOST_MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(HOST_MAX_WAIT);

    grant_t        grant;
    logic          rd_pend;
    logic [AW-1:0] pend_addr;
    issue_tag_t    tag_q;
    issue_tag_t    tag_next;
    logic          host_wr_q;
    logic [WW-1:0] wait_cnt;
    logic          pend_load;

    spi_reg_grant #(
        .AW(AW),
        .DW(DW)
    ) u_grant (
        .spi_wr_en      (spi_wr_en),
        .spi_wr_addr    (spi_wr_addr),
        .spi_wr_data    (spi_wr_data),
        .rd_pend        (rd_pend),
        .pend_addr      (pend_addr),
        .spi_rd_en      (spi_rd_en),
        .spi_rd_addr    (spi_rd_addr),
        .host_req_valid (host_req_valid),
        .host_req_we    (host_req_we),
        .host_req_addr  (host_req_addr),
        .host_req_wdata (host_req_wdata),
        .grant          (grant),
        .host_req_ready (host_req_ready),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata)
    );

    // A live SPI read that loses arbitration parks in the one-deep holding register.
    assign pend_load = spi_rd_en && (grant != GNT_SPI_RD);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend    <= 1'b0;
            pend_addr  <= '0;
            spi_rd_ovf <= 1'b0;
        end else if (pend_load) begin
            rd_pend   <= 1'b1;
            pend_addr <= spi_rd_addr;
            if (rd_pend && grant != GNT_PEND)
                spi_rd_ovf <= 1'b1;
        end else if (grant == GNT_PEND) begin
            rd_pend <= 1'b0;
        end
    end

    always_comb begin
        tag_next = TAG_NONE;
        case (grant)
            GNT_PEND, GNT_SPI_RD: tag_next = TAG_SPI;
            GNT_HOST:             tag_next = TAG_HOST;
            default:              tag_next = TAG_NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q     <= TAG_NONE;
            host_wr_q <= 1'b0;
        end else begin
            tag_q     <= tag_next;
            host_wr_q <= (grant == GNT_HOST) && host_req_we;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spi_rd_data  <= '0;
            spi_rd_valid <= 1'b0;
        end else begin
            spi_rd_valid <= (tag_q == TAG_SPI);
            if (tag_q == TAG_SPI)
                spi_rd_data <= mem_rdata;
        end
    end

    // Host response is taken straight off the RAM port; rst suppresses an in-flight one.
    assign host_rsp_valid = (tag_q == TAG_HOST) && !rst;
    assign host_rsp_rdata = (host_rsp_valid && !host_wr_q) ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt    <= '0;
            host_starve <= 1'b0;
        end else if (host_req_valid && host_req_ready) begin
            wait_cnt <= '0;
        end else if (host_req_valid && wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == WAIT_MAX - 1'b1)
                host_starve <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_regbank_arbiter.sv
// Directed bench for spi_regbank_arbiter with a scoreboard monitor for read/response pulses.
module tb_spi_regbank_arbiter;

    logic        clk;
    logic        rst;
    logic        spi_wr_en;
    logic [8:0]  spi_wr_addr;
    logic [31:0] spi_wr_data;
    logic        spi_rd_en;
    logic [8:0]  spi_rd_addr;
    logic [31:0] spi_rd_data;
    logic        spi_rd_valid;
    logic        host_req_valid;
    logic        host_req_we;
    logic [8:0]  host_req_addr;
    logic [31:0] host_req_wdata;
    logic        host_req_ready;
    logic        host_rsp_valid;
    logic [31:0] host_rsp_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        spi_rd_ovf;
    logic        host_starve;

    spi_regbank_arbiter #(
        .AW(9),
        .DW(32),
        .HOST_MAX_WAIT(64)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .spi_wr_en      (spi_wr_en),
        .spi_wr_addr    (spi_wr_addr),
        .spi_wr_data    (spi_wr_data),
        .spi_rd_en      (spi_rd_en),
        .spi_rd_addr    (spi_rd_addr),
        .spi_rd_data    (spi_rd_data),
        .spi_rd_valid   (spi_rd_valid),
        .host_req_valid (host_req_valid),
        .host_req_we    (host_req_we),
        .host_req_addr  (host_req_addr),
        .host_req_wdata (host_req_wdata),
        .host_req_ready (host_req_ready),
        .host_rsp_valid (host_rsp_valid),
        .host_rsp_rdata (host_rsp_rdata),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .spi_rd_ovf     (spi_rd_ovf),
        .host_starve    (host_starve)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Read-first synchronous RAM model.
    logic [31:0] ram [0:511];
    initial begin
        for (int i = 0; i < 512; i++) ram[i] = '0;
        mem_rdata = '0;
    end
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int unsigned cyc;
    } exp_t;

    exp_t spi_q[$];
    exp_t host_q[$];
    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_spi(input logic [31:0] d, input int unsigned c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        spi_q.push_back(e);
    endtask

    // Monitor: every output pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (spi_rd_valid) begin
            if (spi_q.size() == 0) begin
                check("spi_unexpected_pulse", {96'd0, spi_rd_data}, 128'hDEAD);
            end else begin
                e = spi_q.pop_front();
                check("spi_rd_data", {96'd0, spi_rd_data}, {96'd0, e.data});
                check("spi_rd_cycle", {96'd0, cyc}, {96'd0, e.cyc});
            end
        end
        if (host_rsp_valid) begin
            if (host_q.size() == 0) begin
                check("host_unexpected_pulse", {96'd0, host_rsp_rdata}, 128'hDEAD);
            end else begin
                e = host_q.pop_front();
                check("host_rsp_rdata", {96'd0, host_rsp_rdata}, {96'd0, e.data});
                check("host_rsp_cycle", {96'd0, cyc}, {96'd0, e.cyc});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic spi_set(input logic wr, input logic [8:0] wa, input logic [31:0] wd,
                           input logic rd, input logic [8:0] ra);
        spi_wr_en   = wr;
        spi_wr_addr = wa;
        spi_wr_data = wd;
        spi_rd_en   = rd;
        spi_rd_addr = ra;
    endtask

    task automatic spi_clr();
        spi_set(1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic host_xfer(input logic we, input logic [8:0] a, input logic [31:0] wd,
                             input logic [31:0] exp_rd, input int exp_stall);
        exp_t e;
        int stall = 0;
        bit done = 0;
        host_req_valid = 1'b1;
        host_req_we    = we;
        host_req_addr  = a;
        host_req_wdata = wd;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (host_req_ready) begin
                e.data = exp_rd;
                e.cyc  = cyc + 1;
                host_q.push_back(e);
                done = 1;
            end else begin
                stall++;
            end
            tick();
        end
        host_req_valid = 1'b0;
        host_req_we    = 1'b0;
        check("host_granted", {127'd0, done}, 128'd1);
        check("host_stall_cycles", {96'd0, stall}, {96'd0, exp_stall});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        host_req_valid = 1'b0;
        host_req_we = 1'b0;
        host_req_addr = '0;
        host_req_wdata = '0;
        spi_clr();
        repeat (3) tick();
        @(negedge clk);
        check("reset_outputs",
              {16'd0, spi_rd_data, spi_rd_valid, host_req_ready, host_rsp_valid, host_rsp_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, spi_rd_ovf, host_starve}, 128'd0);
        tick();
        rst = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("idle_outputs",
              {16'd0, spi_rd_data, spi_rd_valid, host_req_ready, host_rsp_valid, host_rsp_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, spi_rd_ovf, host_starve}, 128'd0);
        tick();

        // Host write then uncontended SPI read of the same word.
        host_xfer(1'b1, 9'h010, 32'hAAAA_0787, 32'h0, 0);
        spi_set(1'b0, '0, '0, 1'b1, 9'h010);
        push_spi(32'hAAAA_0787, cyc + 2);
        tick();
        spi_clr();
        repeat (5) tick();
        check("spi_rd_data_hold", {96'd0, spi_rd_data}, {96'd0, 32'hAAAA_0787});

        // Simultaneous write and read: write first, deferred read sees new data.
        spi_set(1'b1, 9'h005, 32'h1234_5678, 1'b1, 9'h005);
        push_spi(32'h1234_5678, cyc + 3);
        tick();
        spi_clr();
        repeat (6) tick();

        // Host read stalled by three back-to-back SPI writes.
        host_xfer(1'b1, 9'h020, 32'h0BAD_F00D, 32'h0, 0);
        fork
            host_xfer(1'b0, 9'h020, 32'h0, 32'h0BAD_F00D, 3);
            begin
                for (int i = 0; i < 3; i++) begin
                    spi_set(1'b1, 9'h030 + 9'(i), 32'h3000_0030 + 32'(i), 1'b0, '0);
                    tick();
                end
                spi_clr();
            end
        join
        spi_set(1'b0, '0, '0, 1'b1, 9'h031);
        push_spi(32'h3000_0031, cyc + 2);
        tick();
        spi_clr();
        repeat (5) tick();

        // Pending read overwritten: only the 0x002 read returns.
        check("ovf_before", {127'd0, spi_rd_ovf}, 128'd0);
        spi_set(1'b1, 9'h001, 32'h1111_0001, 1'b1, 9'h001);
        tick();
        spi_set(1'b1, 9'h002, 32'h2222_0002, 1'b1, 9'h002);
        push_spi(32'h2222_0002, cyc + 3);
        tick();
        spi_clr();
        repeat (6) tick();
        check("ovf_after", {127'd0, spi_rd_ovf}, 128'd1);

        // Starvation: SPI writes every cycle for 70 cycles.
        check("starve_before", {127'd0, host_starve}, 128'd0);
        fork
            host_xfer(1'b0, 9'h030, 32'h0, 32'h3000_0030, 70);
            begin
                for (int i = 0; i < 70; i++) begin
                    spi_set(1'b1, 9'h1FF, 32'(i), 1'b0, '0);
                    @(negedge clk);
                    if (i == 63) check("starve_at_63", {127'd0, host_starve}, 128'd0);
                    if (i == 64) check("starve_at_64", {127'd0, host_starve}, 128'd1);
                    tick();
                end
                spi_clr();
            end
        join
        repeat (3) tick();
        check("starve_sticky", {127'd0, host_starve}, 128'd1);
        check("ovf_sticky", {127'd0, spi_rd_ovf}, 128'd1);

        // Reset mid-read: SPI read in flight and host granted during rst.
        spi_set(1'b0, '0, '0, 1'b1, 9'h010);
        host_req_valid = 1'b1;
        host_req_we    = 1'b0;
        host_req_addr  = 9'h020;
        tick();
        spi_clr();
        rst = 1'b1;
        tick();
        host_req_valid = 1'b0;
        rst = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        check("flags_after_rst", {126'd0, spi_rd_ovf, host_starve}, 128'd0);
        check("spi_rd_data_after_rst", {96'd0, spi_rd_data}, 128'd0);
        tick();

        host_xfer(1'b0, 9'h010, 32'h0, 32'hAAAA_0787, 0);

        for (int i = 0; i < 20 && (spi_q.size() != 0 || host_q.size() != 0); i++) tick();
        check("spi_queue_drained", {96'd0, spi_q.size()}, 128'd0);
        check("host_queue_drained", {96'd0, host_q.size()}, 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
